// File: rtl/pipe_hazard_track_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, link register, destination select.
package pipe_hazard_track_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  localparam logic [4:0] RA_REG_DEF = 5'd31;

  function automatic logic [4:0] sel_dest(
    input logic       jal,
    input logic       regrt,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] ra
  );
    if (jal)
      sel_dest = ra;
    else if (regrt)
      sel_dest = rt;
    else
      sel_dest = rd;
  endfunction

endpackage

// File: rtl/pipe_hazard_track_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_hazard_track.sv
// Load-use stall / control-transfer flush tracker carrying destination info ID->EXE->MEM.
module pipe_hazard_track
  import pipe_hazard_track_pkg::*;
#(
  parameter logic [4:0] RA_REG = RA_REG_DEF,
  parameter int         CNT_W  = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_regrt,
  input  logic             id_jal,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             loaddepeen,
  input  logic [1:0]       pcsource,
  output logic [4:0]       EXE_rd,
  output logic             EXE_wreg,
  output logic             EXE_SLD,
  output logic [4:0]       MEM_rd,
  output logic             MEM_wreg,
  output logic             wpcir,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state;
  hz_state_e  state_nxt;
  logic       stall_p0;
  logic       bubble_p0;
  logic [4:0] dest_p0;

  assign dest_p0   = sel_dest(id_jal, id_regrt, id_rt, id_rd, RA_REG);
  assign stall_p0  = (state == ST_RUN) && !loaddepeen;
  assign bubble_p0 = stall_p0 || (state == ST_FLUSH);

  // Stall wins over a taken transfer; the flush is only scheduled when ID advances.
  always_comb begin
    state_nxt = ST_RUN;
    if ((state == ST_RUN) && loaddepeen && (pcsource != 2'b00))
      state_nxt = ST_FLUSH;
  end

  // pcsource never reaches wpcir; reset forces the PC open immediately.
  assign wpcir = !resetn || !stall_p0;

  // ID -> EXE -> MEM boundary registers plus FSM state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      if_flush <= 1'b0;
      EXE_rd   <= 5'd0;
      EXE_wreg <= 1'b0;
      EXE_SLD  <= 1'b0;
      MEM_rd   <= 5'd0;
      MEM_wreg <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_flush <= (state_nxt == ST_FLUSH);
      MEM_rd   <= EXE_rd;
      MEM_wreg <= EXE_wreg;
      if (bubble_p0) begin
        EXE_rd   <= 5'd0;
        EXE_wreg <= 1'b0;
        EXE_SLD  <= 1'b0;
      end else begin
        EXE_rd   <= dest_p0;
        EXE_wreg <= id_wreg;
        EXE_SLD  <= id_m2reg;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (stall_p0),
    .count  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (state == ST_FLUSH),
    .count  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_track.sv
// Scoreboard bench: driver pushes hand-computed expectations, negedge monitor pops and compares.
module tb_pipe_hazard_track;

  localparam int CNT_W = 16;
  localparam int N_SAT = (1 << CNT_W) + 3;

  logic             clock;
  logic             resetn;
  logic             id_wreg, id_m2reg, id_regrt, id_jal;
  logic [4:0]       id_rt, id_rd;
  logic             loaddepeen;
  logic [1:0]       pcsource;
  logic [4:0]       EXE_rd, MEM_rd;
  logic             EXE_wreg, EXE_SLD, MEM_wreg, wpcir, if_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_track #(.RA_REG(5'd31), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .id_wreg    (id_wreg),
    .id_m2reg   (id_m2reg),
    .id_regrt   (id_regrt),
    .id_jal     (id_jal),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .loaddepeen (loaddepeen),
    .pcsource   (pcsource),
    .EXE_rd     (EXE_rd),
    .EXE_wreg   (EXE_wreg),
    .EXE_SLD    (EXE_SLD),
    .MEM_rd     (MEM_rd),
    .MEM_wreg   (MEM_wreg),
    .wpcir      (wpcir),
    .if_flush   (if_flush),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    bit          chk;
    logic [4:0]  e_rd;
    logic        e_w;
    logic        e_s;
    logic [4:0]  m_rd;
    logic        m_w;
    logic        wp;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_id   = 0;

  task automatic cmp(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Apply one cycle of ID inputs and queue what the monitor must see at the following negedge.
  task automatic vec(
    input logic rn, input logic wreg, input logic m2reg, input logic regrt, input logic jal,
    input logic [4:0] rt, input logic [4:0] rd, input logic ld, input logic [1:0] pcs,
    input logic [4:0] e_rd, input logic e_w, input logic e_s, input logic [4:0] m_rd,
    input logic m_w, input logic wp, input logic fl, input logic [15:0] sc,
    input logic [15:0] fc, input bit chk
  );
    exp_t e;
    @(posedge clock);
    #1;
    resetn = rn; id_wreg = wreg; id_m2reg = m2reg; id_regrt = regrt; id_jal = jal;
    id_rt = rt; id_rd = rd; loaddepeen = ld; pcsource = pcs;
    e.id = row_id; e.chk = chk; e.e_rd = e_rd; e.e_w = e_w; e.e_s = e_s;
    e.m_rd = m_rd; e.m_w = m_w; e.wp = wp; e.fl = fl; e.sc = sc; e.fc = fc;
    q.push_back(e);
    row_id++;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        cmp("exe_rd",    e.id, {11'd0, EXE_rd},   {11'd0, e.e_rd});
        cmp("exe_wreg",  e.id, {15'd0, EXE_wreg}, {15'd0, e.e_w});
        cmp("exe_sld",   e.id, {15'd0, EXE_SLD},  {15'd0, e.e_s});
        cmp("mem_rd",    e.id, {11'd0, MEM_rd},   {11'd0, e.m_rd});
        cmp("mem_wreg",  e.id, {15'd0, MEM_wreg}, {15'd0, e.m_w});
        cmp("wpcir",     e.id, {15'd0, wpcir},    {15'd0, e.wp});
        cmp("if_flush",  e.id, {15'd0, if_flush}, {15'd0, e.fl});
        cmp("stall_cnt", e.id, stall_cnt, e.sc);
        cmp("flush_cnt", e.id, flush_cnt, e.fc);
      end
    end
  end

  initial begin
    resetn = 1'b1; id_wreg = 0; id_m2reg = 0; id_regrt = 0; id_jal = 0;
    id_rt = 0; id_rd = 0; loaddepeen = 1'b0; pcsource = 2'b11;
    #2 resetn = 1'b0;
    //  rn w  m  rt j  id_rt  id_rd  ld pcs    exe_rd w s  mem_rd w  wp fl sc  fc  chk
    vec(0, 1, 1, 1, 0, 5'd3,  5'd9,  0, 2'd3,  5'd0,  0,0, 5'd0,  0, 1, 0, 0,  0,  1); // in reset
    vec(1, 1, 1, 1, 0, 5'd3,  5'd9,  1, 2'd0,  5'd0,  0,0, 5'd0,  0, 1, 0, 0,  0,  1); // lw r3
    vec(1, 1, 0, 0, 0, 5'd0,  5'd5,  0, 2'd0,  5'd3,  1,1, 5'd0,  0, 0, 0, 0,  0,  1); // load-use stall
    vec(1, 1, 0, 0, 0, 5'd0,  5'd5,  1, 2'd0,  5'd0,  0,0, 5'd3,  1, 1, 0, 1,  0,  1); // add rd5 proceeds
    vec(1, 1, 0, 0, 1, 5'd6,  5'd4,  1, 2'd3,  5'd5,  1,0, 5'd0,  0, 1, 0, 1,  0,  1); // jal taken
    vec(1, 1, 0, 0, 0, 5'd0,  5'd8,  0, 2'd1,  5'd31, 1,0, 5'd5,  1, 1, 1, 1,  0,  1); // FLUSH ignores ld/pcs
    vec(1, 1, 0, 0, 0, 5'd0,  5'd7,  1, 2'd0,  5'd0,  0,0, 5'd31, 1, 1, 0, 1,  1,  1); // add rd7
    vec(1, 0, 0, 0, 0, 5'd0,  5'd2,  0, 2'd1,  5'd7,  1,0, 5'd0,  0, 0, 0, 1,  1,  1); // stall beats branch
    vec(1, 0, 0, 0, 0, 5'd0,  5'd0,  1, 2'd0,  5'd0,  0,0, 5'd7,  1, 1, 0, 2,  1,  1); // nop
    vec(1, 1, 1, 1, 0, 5'd6,  5'd0,  1, 2'd2,  5'd0,  0,0, 5'd0,  0, 1, 0, 2,  1,  1); // taken, enter FLUSH
    vec(0, 0, 0, 0, 0, 5'd0,  5'd0,  0, 2'd2,  5'd0,  0,0, 5'd0,  0, 1, 0, 0,  0,  1); // async reset mid-FLUSH
    vec(1, 1, 0, 0, 0, 5'd0,  5'd12, 1, 2'd0,  5'd0,  0,0, 5'd0,  0, 1, 0, 0,  0,  1); // release, add rd12
    vec(1, 0, 0, 0, 0, 5'd0,  5'd0,  1, 2'd0,  5'd12, 1,0, 5'd0,  0, 1, 0, 0,  0,  1);
    vec(1, 0, 0, 0, 0, 5'd0,  5'd0,  1, 2'd0,  5'd0,  0,0, 5'd12, 1, 1, 0, 0,  0,  1);
    // long stall: counter must climb to all-ones and stay there
    for (int i = 0; i < N_SAT; i++) begin
      vec(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 2'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0,
          (i < 16'hFFFF) ? 16'(i) : 16'hFFFF, 16'd0,
          (i == 16'hFFFE) || (i == N_SAT - 1));
    end
    vec(1, 0, 0, 0, 0, 5'd0, 5'd0, 1, 2'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 16'hFFFF, 0, 1);
    repeat (3) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_track.md
PIPE_HAZARD_TRACK -- requirements
Module: pipe_hazard_track

Interface
REQ-001 Parameter: RA_REG, default 5'd31, destination register forced for jal.
REQ-002 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-003 Port: clock  in  1  rising-edge clock for all state.
REQ-004 Port: resetn  in  1  asynchronous, active-low reset.
REQ-005 Port: id_wreg  in  1  ID-stage write-register enable, already gated by load-use stall.
REQ-006 Port: id_m2reg  in  1  ID-stage instruction is a load (lw).
REQ-007 Port: id_regrt  in  1  destination is rt (1) or rd (0).
REQ-008 Port: id_jal  in  1  ID-stage instruction is jal.
REQ-009 Port: id_rt, id_rd  in  5 each  ID-stage rt and rd fields.
REQ-010 Port: loaddepeen  in  1  load-use dependency, active-low (0 = stall requested).
REQ-011 Port: pcsource  in  2  ID-stage next-PC select; non-zero = control transfer taken.
REQ-012 Port: EXE_rd / EXE_wreg / EXE_SLD  out  5/1/1  EXE-stage destination, write enable, load flag.
REQ-013 Port: MEM_rd / MEM_wreg  out  5/1  MEM-stage destination and write enable.
REQ-014 Port: wpcir  out  1  PC and IF/ID register write enable (0 = hold).
REQ-015 Port: if_flush  out  1  squash the instruction now in IF/ID.
REQ-016 Port: stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-017 Destination select: id_jal -> RA_REG; else id_regrt -> id_rt; else id_rd.
REQ-018 FSM states RUN, FLUSH; 1 cycle per state; no other states.
REQ-019 RUN, loaddepeen=0: EXE registers load a bubble (EXE_rd=0, EXE_wreg=0, EXE_SLD=0); wpcir=0 combinationally that cycle; next state RUN; pcsource ignored.
REQ-020 RUN, loaddepeen=1, pcsource=00: EXE registers load selected destination, id_wreg, id_m2reg; wpcir=1; next state RUN.
REQ-021 RUN, loaddepeen=1, pcsource!=00: EXE registers load ID values as in REQ-020; wpcir=1; next state FLUSH.
REQ-022 FLUSH: if_flush=1 (Moore output); EXE registers load a bubble; loaddepeen and pcsource ignored; wpcir=1; next state RUN.
REQ-023 Stall has priority over branch when both occur in RUN.
REQ-024 MEM_rd/MEM_wreg load EXE_rd/EXE_wreg every clock unconditionally; latency ID->EXE 1 cycle, ID->MEM 2 cycles.
REQ-025 stall_cnt increments once per RUN cycle with loaddepeen=0; flush_cnt increments once per FLUSH cycle; both saturate at all-ones, never wrap.
REQ-026 wpcir=0 only in RUN with loaddepeen=0; a stall lasts exactly as long as loaddepeen is held low.

Reset
REQ-027 resetn=0 asynchronously forces state RUN, EXE_rd=0, EXE_wreg=0, EXE_SLD=0, MEM_rd=0, MEM_wreg=0, counters=0.
REQ-028 During reset wpcir=1 and if_flush=0; reset mid-FLUSH abandons the flush.
REQ-029 First edge after resetn release applies RUN rules.

Structure
REQ-030 FSM state encoding and RA_REG constant reside in the shared pipeline package.
REQ-031 One sub-module, sat_counter (CNT_W wide, increment enable, saturate), instantiated twice.
REQ-032 No combinational path from pcsource to wpcir.

Verification
REQ-033 lw r3 (id_m2reg=1,id_regrt=1,id_rt=3) then loaddepeen=0 one cycle -> EXE_rd=3,EXE_SLD=1; next cycle wpcir=0, EXE bubble; MEM_rd=3,MEM_wreg=1; stall_cnt=1.
REQ-034 add rd=7 with pcsource=00 -> EXE_rd=7 next edge, MEM_rd=7 following edge, if_flush never asserted.
REQ-035 jal with pcsource=11 -> EXE_rd=31,EXE_wreg=1; next cycle if_flush=1, EXE bubble; flush_cnt=1; then RUN.
REQ-036 loaddepeen=0 and pcsource=01 same cycle -> wpcir=0, stay RUN, if_flush=0, flush_cnt unchanged.
REQ-037 Hold loaddepeen=0 for 2^CNT_W+3 cycles -> stall_cnt stops at all-ones.
REQ-038 resetn low mid-FLUSH -> all registers 0, if_flush=0, wpcir=1 immediately, without waiting for a clock edge.
